// File: rtl/pixel_write_engine.sv
// Packs 12-bit RGB pixels into 32-bit per-color words, eight pixels per group,
// and writes each group to frame memory as three words: R, G, then B.
module pixel_write_engine #(
  parameter logic [16:0] BASE_ADDR   = 17'd0,
  parameter int unsigned FRAME_WORDS = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_writing,
  input  logic [11:0] in_data,
  input  logic        in_rts,
  output logic        in_rtr,
  output logic [16:0] out_addr,
  output logic [31:0] out_data,
  output logic        out_rts,
  input  logic        out_rtr,
  output logic        frame_done
);

  localparam logic [16:0] LAST_ADDR = BASE_ADDR + 17'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {ACCUM, WR_R, WR_G, WR_B} state_e;

  state_e      state_q,     state_d;
  logic [2:0]  pixCnt_q,    pixCnt_d;
  logic [31:0] rShift_q,    rShift_d;
  logic [31:0] gShift_q,    gShift_d;
  logic [31:0] bShift_q,    bShift_d;
  logic        inRtr_q,     inRtr_d;
  logic        outRts_q,    outRts_d;
  logic [16:0] outAddr_q,   outAddr_d;
  logic [31:0] outData_q,   outData_d;
  logic        frameDone_q, frameDone_d;

  logic inXfer;
  logic outXfer;

  assign inXfer  = in_rts & inRtr_q;
  assign outXfer = outRts_q & out_rtr;

  // Only one group is buffered, so input is refused while the three words drain.
  always_comb begin
    state_d     = state_q;
    pixCnt_d    = pixCnt_q;
    rShift_d    = rShift_q;
    gShift_d    = gShift_q;
    bShift_d    = bShift_q;
    inRtr_d     = inRtr_q;
    outRts_d    = outRts_q;
    outAddr_d   = outAddr_q;
    outData_d   = outData_q;
    frameDone_d = 1'b0;

    unique case (state_q)
      ACCUM: begin
        inRtr_d = 1'b1;
        if (inXfer) begin
          rShift_d = {rShift_q[27:0], in_data[11:8]};
          gShift_d = {gShift_q[27:0], in_data[7:4]};
          bShift_d = {bShift_q[27:0], in_data[3:0]};
          pixCnt_d = pixCnt_q + 3'd1;
          if (pixCnt_q == 3'd7) begin
            state_d   = WR_R;
            inRtr_d   = 1'b0;
            outRts_d  = 1'b1;
            outData_d = {rShift_q[27:0], in_data[11:8]};
          end
        end
      end
      WR_R: begin
        if (outXfer) begin
          state_d   = WR_G;
          outAddr_d = outAddr_q + 17'd1;
          outData_d = gShift_q;
        end
      end
      WR_G: begin
        if (outXfer) begin
          state_d   = WR_B;
          outAddr_d = outAddr_q + 17'd1;
          outData_d = bShift_q;
        end
      end
      WR_B: begin
        if (outXfer) begin
          state_d  = ACCUM;
          outRts_d = 1'b0;
          inRtr_d  = 1'b1;
          // Wrap by comparison so frames need not be a power-of-two size.
          if (outAddr_q == LAST_ADDR) begin
            outAddr_d   = BASE_ADDR;
            frameDone_d = 1'b1;
          end else begin
            outAddr_d = outAddr_q + 17'd1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase

    if (!en_writing) begin
      state_d     = ACCUM;
      pixCnt_d    = 3'd0;
      rShift_d    = 32'd0;
      gShift_d    = 32'd0;
      bShift_d    = 32'd0;
      inRtr_d     = 1'b0;
      outRts_d    = 1'b0;
      outAddr_d   = BASE_ADDR;
      outData_d   = 32'd0;
      frameDone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      pixCnt_q    <= 3'd0;
      rShift_q    <= 32'd0;
      gShift_q    <= 32'd0;
      bShift_q    <= 32'd0;
      inRtr_q     <= 1'b0;
      outRts_q    <= 1'b0;
      outAddr_q   <= BASE_ADDR;
      outData_q   <= 32'd0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixCnt_q    <= pixCnt_d;
      rShift_q    <= rShift_d;
      gShift_q    <= gShift_d;
      bShift_q    <= bShift_d;
      inRtr_q     <= inRtr_d;
      outRts_q    <= outRts_d;
      outAddr_q   <= outAddr_d;
      outData_q   <= outData_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign in_rtr     = inRtr_q;
  assign out_rts    = outRts_q;
  assign out_addr   = outAddr_q;
  assign out_data   = outData_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_pixel_write_engine.sv
// Directed bench for pixel_write_engine: a default-frame instance plus a tiny
// six-word frame instance driven in lockstep to exercise address wrap.
module tb_pixel_write_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_writing;
  logic [11:0] in_data;
  logic        in_rts;
  logic        in_rtr;
  logic [16:0] out_addr;
  logic [31:0] out_data;
  logic        out_rts;
  logic        out_rtr;
  logic        frame_done;

  logic        inRtrB;
  logic [16:0] outAddrB;
  logic [31:0] outDataB;
  logic        outRtsB;
  logic        frameDoneB;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [7:0][11:0] PAT1 = {12'h678, 12'h345, 12'h012, 12'hDEF,
                                       12'hABC, 12'h789, 12'h456, 12'h123};
  localparam logic [7:0][11:0] PAT2 = {12'h0F0, 12'hF00, 12'h00F, 12'h0F0,
                                       12'hF00, 12'h00F, 12'h0F0, 12'hF00};

  pixel_write_engine dutMain (
    .clk(clk), .rst(rst), .en_writing(en_writing),
    .in_data(in_data), .in_rts(in_rts), .in_rtr(in_rtr),
    .out_addr(out_addr), .out_data(out_data), .out_rts(out_rts),
    .out_rtr(out_rtr), .frame_done(frame_done)
  );

  pixel_write_engine #(.BASE_ADDR(17'h100), .FRAME_WORDS(6)) dutWrap (
    .clk(clk), .rst(rst), .en_writing(en_writing),
    .in_data(in_data), .in_rts(in_rts), .in_rtr(inRtrB),
    .out_addr(outAddrB), .out_data(outDataB), .out_rts(outRtsB),
    .out_rtr(out_rtr), .frame_done(frameDoneB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendPixel(input logic [11:0] px);
    int waited = 0;
    in_data = px;
    in_rts  = 1'b1;
    while (!in_rtr && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_rtr) checkOutput("in_rtr_timeout", {31'd0, in_rtr}, 32'd1);
    tick();
    in_rts  = 1'b0;
    in_data = 12'h000;
  endtask

  // Feeds one group; maxGap > 0 inserts random idle cycles with junk data.
  task automatic applyStimulus(input logic [7:0][11:0] px, input int maxGap);
    for (int i = 0; i < 8; i++) begin
      if (maxGap > 0) begin
        int gap = int'($urandom_range(0, maxGap));
        for (int g = 0; g < gap; g++) begin
          in_rts  = 1'b0;
          in_data = 12'($urandom);
          tick();
        end
      end
      sendPixel(px[i]);
    end
  endtask

  task automatic expectWrite(input string tag, input logic [16:0] addrA,
                             input logic [16:0] addrB, input logic [31:0] data);
    checkOutput({tag, "_rts"},   {31'd0, out_rts}, 32'd1);
    checkOutput({tag, "_addr"},  {15'd0, out_addr}, {15'd0, addrA});
    checkOutput({tag, "_data"},  out_data, data);
    checkOutput({tag, "_addrB"}, {15'd0, outAddrB}, {15'd0, addrB});
    checkOutput({tag, "_dataB"}, outDataB, data);
    tick();
  endtask

  task automatic endGroup(input string tag, input logic fdB);
    checkOutput({tag, "_rts_low"}, {31'd0, out_rts}, 32'd0);
    checkOutput({tag, "_rtsB_low"}, {31'd0, outRtsB}, 32'd0);
    checkOutput({tag, "_rtr_high"}, {31'd0, in_rtr}, 32'd1);
    checkOutput({tag, "_rtrB_high"}, {31'd0, inRtrB}, 32'd1);
    checkOutput({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    checkOutput({tag, "_doneB"}, {31'd0, frameDoneB}, {31'd0, fdB});
    if (fdB) begin
      tick();
      checkOutput({tag, "_doneB_pulse"}, {31'd0, frameDoneB}, 32'd0);
      checkOutput({tag, "_addrB_wrap"}, {15'd0, outAddrB}, 32'h100);
    end
  endtask

  initial begin
    rst        = 1'b1;
    en_writing = 1'b1;
    in_data    = 12'h000;
    in_rts     = 1'b0;
    out_rtr    = 1'b1;
    tick();
    tick();

    checkOutput("rst_in_rtr",   {31'd0, in_rtr}, 32'd0);
    checkOutput("rst_out_rts",  {31'd0, out_rts}, 32'd0);
    checkOutput("rst_out_addr", {15'd0, out_addr}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_done",     {31'd0, frame_done}, 32'd0);
    checkOutput("rst_addrB",    {15'd0, outAddrB}, 32'h100);

    rst = 1'b0;
    tick();
    checkOutput("post_rst_rtr", {31'd0, in_rtr}, 32'd1);

    // Packing with a ready memory
    applyStimulus(PAT1, 0);
    checkOutput("g1_in_rtr_low", {31'd0, in_rtr}, 32'd0);
    expectWrite("g1_r", 17'd0, 17'h100, 32'h147AD036);
    expectWrite("g1_g", 17'd1, 17'h101, 32'h258BE147);
    expectWrite("g1_b", 17'd2, 17'h102, 32'h369CF258);
    endGroup("g1", 1'b0);

    // Backpressure in WR_R with a pixel offered throughout
    out_rtr = 1'b0;
    applyStimulus(PAT2, 0);
    in_rts  = 1'b1;
    in_data = 12'hFFF;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_in_rtr", {31'd0, in_rtr}, 32'd0);
      checkOutput("bp_out_rts", {31'd0, out_rts}, 32'd1);
      tick();
    end
    checkOutput("bp_addr_hold", {15'd0, out_addr}, 32'd3);
    checkOutput("bp_data_hold", out_data, 32'hF00F00F0);
    in_rts  = 1'b0;
    out_rtr = 1'b1;
    expectWrite("g2_r", 17'd3, 17'h103, 32'hF00F00F0);
    expectWrite("g2_g", 17'd4, 17'h104, 32'h0F00F00F);
    expectWrite("g2_b", 17'd5, 17'h105, 32'h00F00F00);
    endGroup("g2", 1'b1);

    // Gapped input stream packs identically to a contiguous one
    applyStimulus(PAT1, 2);
    expectWrite("g3_r", 17'd6, 17'h100, 32'h147AD036);
    expectWrite("g3_g", 17'd7, 17'h101, 32'h258BE147);
    expectWrite("g3_b", 17'd8, 17'h102, 32'h369CF258);
    endGroup("g3", 1'b0);

    // Disable mid-group drops the partial group and rewinds the address
    for (int i = 0; i < 5; i++) sendPixel(12'h5A5);
    en_writing = 1'b0;
    tick();
    checkOutput("dis_in_rtr", {31'd0, in_rtr}, 32'd0);
    checkOutput("dis_addr",   {15'd0, out_addr}, 32'd0);
    checkOutput("dis_addrB",  {15'd0, outAddrB}, 32'h100);
    en_writing = 1'b1;
    applyStimulus(PAT2, 0);
    expectWrite("g4_r", 17'd0, 17'h100, 32'hF00F00F0);
    expectWrite("g4_g", 17'd1, 17'h101, 32'h0F00F00F);
    expectWrite("g4_b", 17'd2, 17'h102, 32'h00F00F00);
    endGroup("g4", 1'b0);

    // Second group of the tiny frame wraps and pulses frame_done
    applyStimulus(PAT1, 1);
    expectWrite("g5_r", 17'd3, 17'h103, 32'h147AD036);
    expectWrite("g5_g", 17'd4, 17'h104, 32'h258BE147);
    expectWrite("g5_b", 17'd5, 17'h105, 32'h369CF258);
    endGroup("g5", 1'b1);

    applyStimulus(PAT2, 0);
    expectWrite("g6_r", 17'd6, 17'h100, 32'hF00F00F0);
    expectWrite("g6_g", 17'd7, 17'h101, 32'h0F00F00F);
    expectWrite("g6_b", 17'd8, 17'h102, 32'h00F00F00);
    endGroup("g6", 1'b0);

    // Asynchronous reset while the G word is pending
    applyStimulus(PAT1, 0);
    tick();
    checkOutput("wrg_addr", {15'd0, out_addr}, 32'd10);
    checkOutput("wrg_data", out_data, 32'h258BE147);
    rst = 1'b1;
    #1;
    checkOutput("arst_out_rts",  {31'd0, out_rts}, 32'd0);
    checkOutput("arst_in_rtr",   {31'd0, in_rtr}, 32'd0);
    checkOutput("arst_out_addr", {15'd0, out_addr}, 32'd0);
    checkOutput("arst_out_data", out_data, 32'd0);
    checkOutput("arst_addrB",    {15'd0, outAddrB}, 32'h100);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("arst_release_rtr", {31'd0, in_rtr}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
